// File: rtl/rr_mux16_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux16_arbiter
//
// Round-robin arbiter sharing one 16:1 multiplexer channel (mux_16x1) between
// 16 requesters. The registered index `sel` drives the mux select lines
// (sel[0..3] -> s0..s3). The winner receives a one-hot grant. A tenure is cut
// short after MAX_HOLD cycles whenever another requester is waiting.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles while another request is
//             pending (legal range 1..255, and 2**CNTW > MAX_HOLD)
//   CNTW      width of the tenure counter
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   req     in   [15:0] request vector, bit i = requester i wants the channel
//   gnt     out  [15:0] one-hot grant, zero when idle (registered)
//   sel     out  [3:0]  index of current/last grant, drives mux s3..s0
//   active  out  high while a grant is held (registered)
//   sw      out  one-cycle pulse when gnt takes a new non-zero value
// -----------------------------------------------------------------------------
module rr_mux16_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNTW     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        active,
    output logic        sw
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam logic [CNTW-1:0] HOLD_LIMIT = CNTW'(MAX_HOLD);

    // A bad configuration stops elaboration instead of producing an arbiter
    // whose preemption threshold silently wraps.
    generate
        if (MAX_HOLD < 1 || (MAX_HOLD >> CNTW) != 0) begin : g_cfg_error
            $fatal(1, "rr_mux16_arbiter: MAX_HOLD=%0d illegal for CNTW=%0d",
                   MAX_HOLD, CNTW);
        end
    endgenerate

    // First set bit of r, scanning start, start+1, ... with 15 wrapping to 0.
    // Callers only use the result when r is non-zero.
    function automatic logic [3:0] scan(input logic [15:0] r,
                                        input logic [3:0]  start);
        logic [3:0] idx;
        logic       found;
        scan  = start;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = start + 4'(k);
            if (!found && r[idx]) begin
                scan  = idx;
                found = 1'b1;
            end
        end
    endfunction

    logic            state_q, state_d;
    logic [3:0]      sel_q, sel_d;
    logic [3:0]      ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [15:0]     gnt_q, gnt_d;
    logic            sw_q, sw_d;

    logic [15:0]     others;
    logic [3:0]      next_start;

    // Requests excluding the current holder; the holder is never chosen again
    // on a release or preemption, so it gets masked out of the scan.
    assign others     = req & ~(16'd1 << sel_q);
    assign next_start = sel_q + 4'd1;

    always_comb begin
        // NOTE: every variable gets a default first so no path can leave one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sw_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 16'd0) begin
                    state_d = ST_GRANT;
                    sel_d   = scan(req, ptr_q);
                    cnt_d   = CNTW'(1);
                    sw_d    = 1'b1;
                end
            end

            default: begin
                if (!req[sel_q] || (cnt_q >= HOLD_LIMIT && others != 16'd0)) begin
                    // Release or preemption: hand over immediately (no dead
                    // cycle) if anyone else waits, otherwise drop to idle.
                    ptr_d = next_start;
                    if (others != 16'd0) begin
                        sel_d = scan(others, next_start);
                        cnt_d = CNTW'(1);
                        sw_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q < HOLD_LIMIT) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                // else: sole requester past its limit; counter saturates so
                // the first competing request preempts at once.
            end
        endcase

        gnt_d = (state_d == ST_GRANT) ? (16'd1 << sel_d) : 16'd0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 4'd0;
            ptr_q   <= 4'd0;
            cnt_q   <= '0;
            gnt_q   <= 16'd0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sw_q    <= sw_d;
        end
    end

    assign gnt    = gnt_q;
    assign sel    = sel_q;
    assign active = state_q;
    assign sw     = sw_q;

endmodule

// File: tb/tb_rr_mux16_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux16_arbiter
//
// Directed test of rr_mux16_arbiter (MAX_HOLD=8). A behavioural model tracks
// who should own the channel; a compare loop checks all outputs every cycle,
// and literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_rr_mux16_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req   = 16'd0;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        active;
    logic        sw;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    rr_mux16_arbiter #(.MAX_HOLD(MAX_HOLD), .CNTW(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .sel    (sel),
        .active (active),
        .sw     (sw)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_owner  = 0;   // requester owning (or last owning) the channel
    int m_next   = 0;   // where the next search begins
    int m_tenure = 0;   // cycles the current owner has held the channel
    bit m_busy   = 0;
    bit m_new    = 0;

    function automatic int first_from(input logic [15:0] r, input int start);
        for (int k = 0; k < 16; k++)
            if (r[(start + k) % 16]) return (start + k) % 16;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owner = 0; m_next = 0; m_tenure = 0; m_busy = 0; m_new = 0;
        end else if (!m_busy) begin
            m_new = (req != 16'd0);
            if (m_new) begin
                m_owner  = first_from(req, m_next);
                m_busy   = 1;
                m_tenure = 1;
            end
        end else begin
            logic [15:0] waiting;
            waiting          = req;
            waiting[m_owner] = 1'b0;
            m_new            = 0;
            if (!req[m_owner] || (m_tenure >= MAX_HOLD && waiting != 16'd0)) begin
                m_next = (m_owner + 1) % 16;
                if (waiting != 16'd0) begin
                    m_owner  = first_from(waiting, m_next);
                    m_tenure = 1;
                    m_new    = 1;
                end else begin
                    m_busy = 0;
                end
            end else if (m_tenure < MAX_HOLD) begin
                m_tenure++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (check_en && rst_n) begin
            check("model_gnt",    gnt,           m_busy ? (16'd1 << m_owner) : 16'd0);
            check("model_sel",    16'(sel),      16'(m_owner));
            check("model_active", 16'(active),   16'(m_busy));
            check("model_sw",     16'(sw),       16'(m_new));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [15:0] e_gnt,
                              input logic [3:0] e_sel, input logic e_act,
                              input logic e_sw);
        check({tag, "_gnt"},    gnt,         e_gnt);
        check({tag, "_sel"},    16'(sel),    16'(e_sel));
        check({tag, "_active"}, 16'(active), 16'(e_act));
        check({tag, "_sw"},     16'(sw),     16'(e_sw));
    endtask

    logic [15:0] vec_tbl [10] = '{16'hFFFF, 16'h0000, 16'h8001, 16'h0101,
                                  16'hAAAA, 16'h5555, 16'h0010, 16'hFFFF,
                                  16'h0000, 16'h1248};

    initial begin
        // Reset held with every requester asserted, released between edges.
        req = 16'hFFFF;
        tick(3);
        #2 rst_n = 1'b1;
        #1 expect_out("rst_rel", 16'h0000, 4'd0, 1'b0, 1'b0);
        check_en = 1'b1;
        tick(1);
        expect_out("rst_first", 16'h0001, 4'd0, 1'b1, 1'b1);

        // Single requester, held 20 cycles without a switch.
        req = 16'h0000;
        tick(1);
        expect_out("idle", 16'h0000, 4'd0, 1'b0, 1'b0);
        req = 16'h0020;
        tick(1);
        expect_out("single", 16'h0020, 4'd5, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("single_hold_sw", 16'(sw), 16'd0);
        end
        check("single_hold_gnt", gnt, 16'h0020);
        req = 16'h0000;
        tick(1);

        // Fairness: two constant requesters alternate every MAX_HOLD cycles.
        req = 16'h0208;
        #2 rst_n = 1'b0;
        tick(1);
        #2 rst_n = 1'b1;
        tick(1);
        expect_out("fair_a", 16'h0008, 4'd3, 1'b1, 1'b1);
        tick(7);
        expect_out("fair_a_end", 16'h0008, 4'd3, 1'b1, 1'b0);
        tick(1);
        expect_out("fair_b", 16'h0200, 4'd9, 1'b1, 1'b1);
        tick(7);
        expect_out("fair_b_end", 16'h0200, 4'd9, 1'b1, 1'b0);
        tick(1);
        expect_out("fair_a2", 16'h0008, 4'd3, 1'b1, 1'b1);
        req = 16'h0000;
        tick(1);

        // Wrap-around: grant 14, release -> search starts at 15.
        req = 16'h4000;
        tick(1);
        check("wrap_14", 16'(sel), 16'd14);
        req = 16'h0000;
        tick(1);
        check("wrap_idle", 16'(active), 16'd0);
        req = 16'h8002;
        tick(1);
        expect_out("wrap_15", 16'h8000, 4'd15, 1'b1, 1'b1);
        req = 16'h0002;
        tick(1);
        expect_out("wrap_1", 16'h0002, 4'd1, 1'b1, 1'b1);
        req = 16'h0000;
        tick(1);

        // Early release hands over at once; counter restarts for new owner.
        req = 16'h0084;
        tick(1);
        check("early_2", 16'(sel), 16'd2);
        tick(2);
        req = 16'h0080;
        tick(1);
        expect_out("early_7", 16'h0080, 4'd7, 1'b1, 1'b1);
        req = 16'h0081;
        tick(7);
        expect_out("early_7_end", 16'h0080, 4'd7, 1'b1, 1'b0);
        tick(1);
        expect_out("early_0", 16'h0001, 4'd0, 1'b1, 1'b1);
        req = 16'h0000;
        tick(1);

        // Asynchronous reset in the middle of a tenure.
        req = 16'h0800;
        tick(1);
        check("async_11", 16'(sel), 16'd11);
        tick(1);
        #2 rst_n = 1'b0;
        #1 expect_out("async_clr", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick(1);
        #2 rst_n = 1'b1;
        tick(1);
        expect_out("async_regrant", 16'h0800, 4'd11, 1'b1, 1'b1);

        // Assorted vectors, checked against the model every cycle.
        for (int v = 0; v < 10; v++) begin
            req = vec_tbl[v];
            tick(10);
        end
        req = 16'h0000;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
